neopixel_rx: RTL and testbench

WS2812-style single-wire pixel receiver: the decode end of the NeoPixel link the team's transmitter drives. It samples `np_in`, classifies each high pulse as a 0 or 1 bit by its width, and assembles 24-bit pixel words MSB-first. It detects the ≥50 µs low latch gap as end-of-frame and exposes pixel, status and frame pixel count on the same simple bus used by the transmitter. It sits on the SmartFusion fabric bus, typically looped back from the transmitter's output for self-test or driven by an external controller.

---
 rtl/neopixel_pkg.sv | 37 +++
 rtl/neopixel_rx_if.sv | 19 +
 rtl/neopixel_rx_sync.sv | 36 +++
 rtl/neopixel_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_neopixel_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neopixel_pkg.sv
// Shared constants for the NeoPixel link: register map, status bit positions,
// default pulse timing (shared with the transmitter) and receiver FSM states.
package neopixel_pkg;

   localparam int BIT_THRESH   = 15;
   localparam int MIN_HIGH     = 3;
   localparam int MAX_HIGH     = 40;
   localparam int RESET_CYCLES = 1250;

   localparam logic [7:0] REG_STATUS = 8'h00;
   localparam logic [7:0] REG_CTRL   = 8'h04;

   // read-side positions in REG_STATUS
   localparam int ST_VALID = 24;
   localparam int ST_DONE  = 25;
   localparam int ST_ERR   = 26;
   localparam int ST_OVR   = 27;

   // write-side command bits in REG_STATUS
   localparam int WR_CLR_OVR  = 24;
   localparam int WR_CLR_ERR  = 25;
   localparam int WR_CLR_DONE = 26;
   localparam int WR_IRQ_LD   = 27;
   localparam int WR_IRQ_VAL  = 28;

   typedef enum logic [1:0] {
      S_ARM  = 2'd0,
      S_IDLE = 2'd1,
      S_HIGH = 2'd2,
      S_LOW  = 2'd3
   } rx_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/neopixel_rx_if.sv
// Simple fabric bus shared by the NeoPixel transmitter and receiver.
interface neopixel_rx_if;
   logic        bus_write_en;
   logic        bus_read_en;
   logic        np_en;
   logic [7:0]  bus_addr;
   logic [31:0] bus_write_data;
   logic [31:0] bus_read_data;

   modport master (
      output bus_write_en, bus_read_en, np_en, bus_addr, bus_write_data,
      input  bus_read_data
   );

   modport slave (
      input  bus_write_en, bus_read_en, np_en, bus_addr, bus_write_data,
      output bus_read_data
   );
endinterface

// File: rtl/neopixel_rx_sync.sv
// np_sync: 2-flop synchronizer for the asynchronous line plus a 1-flop delay
// giving single-cycle rise/fall strobes aligned with the synchronized level.
module np_sync (
   input  logic pclk,
   input  logic nreset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic dly_q, dly_d;

   always_comb begin
      s1_d  = din;
      s2_d  = s1_q;
      dly_d = s2_q;
   end

   always_ff @(posedge pclk) begin
      if (!nreset) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         dly_q <= 1'b0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         dly_q <= dly_d;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~dly_q;
   assign fall  = ~s2_q & dly_q;
endmodule

// File: rtl/neopixel_rx.sv
// WS2812-style pixel receiver: pulse-width bit decode, 24-bit pixel assembly,
// latch-gap frame detection and a small register file. Define
// NEOPIXEL_RX_FWD_EN to add the np_fwd_out daisy-chain forwarding port.
//
// state  | meaning
// ARM    | waiting for RESET_CYCLES of continuous low before accepting data
// IDLE   | line quiet between frames, waiting for first rising edge
// HIGH   | measuring a high pulse (hi_cnt)
// LOW    | measuring low time after a bit (lo_cnt); latch gap ends the frame
module neopixel_rx
   import neopixel_pkg::*;
#(
   parameter int BIT_THRESH_P   = BIT_THRESH,
   parameter int MIN_HIGH_P     = MIN_HIGH,
   parameter int MAX_HIGH_P     = MAX_HIGH,
   parameter int RESET_CYCLES_P = RESET_CYCLES
) (
   input  logic          pclk,
   input  logic          nreset,
   neopixel_rx_if.slave  bus,
   input  logic          np_in,
   output logic          np_irq
`ifdef NEOPIXEL_RX_FWD_EN
   ,
   output logic          np_fwd_out
`endif
);
   localparam int HI_W = $clog2(MAX_HIGH_P + 1);
   localparam int LO_W = 14;
   localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);
   localparam logic [HI_W-1:0] THR_C  = HI_W'(BIT_THRESH_P);
   localparam logic [HI_W-1:0] MIN_C  = HI_W'(MIN_HIGH_P);
   localparam logic [HI_W-1:0] MAX_C  = HI_W'(MAX_HIGH_P);
   localparam logic [LO_W-1:0] LO_ONE = LO_W'(1);
   localparam logic [LO_W-1:0] RC_C   = LO_W'(RESET_CYCLES_P);

   logic level, rise, fall;

   np_sync u_sync (
      .pclk   (pclk),
      .nreset (nreset),
      .din    (np_in),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   rx_state_e       state_q, state_d;
   logic [HI_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [LO_W-1:0] lo_cnt_q, lo_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [23:0]     shift_q, shift_d;
   logic [23:0]     pixel_q, pixel_d;
   logic [7:0]      pix_cnt_q, pix_cnt_d;
   logic [7:0]      last_pix_q, last_pix_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            irq_en_q, irq_en_d;
   logic            irq_q, irq_d;

   logic valid_set, ovr_set, err_set, done_set;
   logic capture_en;
   logic new_bit;

   always_comb begin
      state_d    = state_q;
      hi_cnt_d   = hi_cnt_q;
      lo_cnt_d   = lo_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pixel_d    = pixel_q;
      pix_cnt_d  = pix_cnt_q;
      last_pix_d = last_pix_q;
      valid_set  = 1'b0;
      ovr_set    = 1'b0;
      err_set    = 1'b0;
      done_set   = 1'b0;
      new_bit    = (hi_cnt_q >= THR_C);

      case (state_q)
         S_ARM: begin
            if (level) begin
               lo_cnt_d = '0;
            end else if (lo_cnt_q + LO_ONE >= RC_C) begin
               lo_cnt_d = '0;
               state_d  = S_IDLE;
            end else begin
               lo_cnt_d = lo_cnt_q + LO_ONE;
            end
         end
         S_IDLE: begin
            if (rise) begin
               hi_cnt_d = HI_ONE;
               state_d  = S_HIGH;
            end
         end
         S_HIGH: begin
            if (fall) begin
               if (hi_cnt_q < MIN_C) begin
                  err_set   = 1'b1;
                  bit_cnt_d = '0;
                  lo_cnt_d  = '0;
                  state_d   = S_ARM;
               end else begin
                  lo_cnt_d = LO_ONE;
                  state_d  = S_LOW;
                  if (capture_en) begin
                     shift_d = {shift_q[22:0], new_bit};
                     if (bit_cnt_q == 5'd23) begin
                        pixel_d   = shift_d;
                        valid_set = 1'b1;
                        ovr_set   = valid_q;
                        pix_cnt_d = sat_inc8(pix_cnt_q);
                        bit_cnt_d = '0;
                     end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                     end
                  end
               end
            end else if (hi_cnt_q >= MAX_C) begin
               err_set   = 1'b1;
               bit_cnt_d = '0;
               lo_cnt_d  = '0;
               state_d   = S_ARM;
            end else begin
               hi_cnt_d = hi_cnt_q + HI_ONE;
            end
         end
         S_LOW: begin
            if (rise) begin
               hi_cnt_d = HI_ONE;
               state_d  = S_HIGH;
            end else if (lo_cnt_q >= RC_C) begin
               done_set   = 1'b1;
               err_set    = (bit_cnt_q != 5'd0);
               last_pix_d = pix_cnt_q;
               pix_cnt_d  = '0;
               bit_cnt_d  = '0;
               state_d    = S_IDLE;
            end else begin
               lo_cnt_d = lo_cnt_q + LO_ONE;
            end
         end
         default: state_d = S_ARM;
      endcase
   end

   logic rd_sel, wr_sel, rd_stat, wr_stat;
   logic [31:0] wdata;
   logic [31:0] rdata;

   assign rd_sel  = bus.np_en & bus.bus_read_en;
   assign wr_sel  = bus.np_en & bus.bus_write_en;
   assign rd_stat = rd_sel & (bus.bus_addr == REG_STATUS);
   assign wr_stat = wr_sel & (bus.bus_addr == REG_STATUS);
   assign wdata   = bus.bus_write_data;

   // every set term is ORed last so a same-cycle event beats a clear
   always_comb begin
      valid_d  = valid_set | (valid_q & ~rd_stat);
      ovr_d    = ovr_set   | (ovr_q   & ~(wr_stat & wdata[WR_CLR_OVR]));
      err_d    = err_set   | (err_q   & ~(wr_stat & wdata[WR_CLR_ERR]));
      done_d   = done_set  | (done_q  & ~(wr_stat & wdata[WR_CLR_DONE]));
      irq_en_d = (wr_stat & wdata[WR_IRQ_LD]) ? wdata[WR_IRQ_VAL] : irq_en_q;
      irq_d    = irq_en_q & (done_q | err_q);
   end

   always_comb begin
      rdata = '0;
      if (rd_sel) begin
         case (bus.bus_addr)
            REG_STATUS: rdata = {4'b0, ovr_q, err_q, done_q, valid_q, pixel_q};
            REG_CTRL:   rdata = {23'b0, irq_en_q, last_pix_q};
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.bus_read_data = rdata;
   assign np_irq            = irq_q;

   logic unused_wdata;
   assign unused_wdata = ^{wdata[31:29], wdata[23:0]};

   always_ff @(posedge pclk) begin
      if (!nreset) begin
         state_q    <= S_ARM;
         hi_cnt_q   <= '0;
         lo_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         pixel_q    <= '0;
         pix_cnt_q  <= '0;
         last_pix_q <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_cnt_q   <= hi_cnt_d;
         lo_cnt_q   <= lo_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         pixel_q    <= pixel_d;
         pix_cnt_q  <= pix_cnt_d;
         last_pix_q <= last_pix_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
         err_q      <= err_d;
         done_q     <= done_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
      end
   end

`ifdef NEOPIXEL_RX_FWD_EN
   // once the first pixel of a frame is captured, later bits pass downstream
   logic fwd_q, fwd_d;

   always_comb begin
      fwd_d = fwd_q;
      if (err_set | done_set) begin
         fwd_d = 1'b0;
      end else if (valid_set) begin
         fwd_d = 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (!nreset) begin
         fwd_q <= 1'b0;
      end else begin
         fwd_q <= fwd_d;
      end
   end

   assign capture_en = ~fwd_q;
   assign np_fwd_out = fwd_q & level;
`else
   assign capture_en = 1'b1;
`endif

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: drives WS2812 waveforms on np_in and checks
// the register file and interrupt against hand-computed values.
module tb_neopixel_rx;
   import neopixel_pkg::*;

   logic pclk   = 1'b0;
   logic nreset = 1'b0;
   logic np_in  = 1'b0;
   logic np_irq;
`ifdef NEOPIXEL_RX_FWD_EN
   logic np_fwd_out;
   logic [2:0] fwd_hist;
   int         fwd_bad;
   int         fwd_ticks;
`endif

   int n_vec = 0;
   int n_err = 0;

   neopixel_rx_if bus_if ();

   neopixel_rx dut (
      .pclk   (pclk),
      .nreset (nreset),
      .bus    (bus_if),
      .np_in  (np_in),
      .np_irq (np_irq)
`ifdef NEOPIXEL_RX_FWD_EN
      ,
      .np_fwd_out (np_fwd_out)
`endif
   );

   always #20 pclk = ~pclk;

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: simulation did not finish within 90000 cycles");
      $fatal(1);
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic send_bit_w(input int hi, input int lo);
      np_in = 1'b1;
      cycles(hi);
      np_in = 1'b0;
      cycles(lo);
   endtask

   // nominal encoding: 0 = 10 high / 21 low, 1 = 20 high / 11 low
   task automatic send_bits(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         if (v[i]) send_bit_w(20, 11);
         else      send_bit_w(10, 21);
      end
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      bus_if.np_en       = 1'b1;
      bus_if.bus_read_en = 1'b1;
      bus_if.bus_addr    = a;
      #1 d = bus_if.bus_read_data;
      @(negedge pclk);
      bus_if.np_en       = 1'b0;
      bus_if.bus_read_en = 1'b0;
   endtask

   task automatic wr(input logic [31:0] data);
      bus_if.np_en          = 1'b1;
      bus_if.bus_write_en   = 1'b1;
      bus_if.bus_addr       = REG_STATUS;
      bus_if.bus_write_data = data;
      @(negedge pclk);
      bus_if.np_en          = 1'b0;
      bus_if.bus_write_en   = 1'b0;
      bus_if.bus_write_data = '0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      nreset = 1'b0;
      np_in  = 1'b0;
      cycles(4);
      #1;
      n_vec++;
      if (np_irq !== 1'b0) begin
         n_err++; $display("FAIL reset_irq: got %b expected 0", np_irq);
      end
      n_vec++;
      if (bus_if.bus_read_data !== 32'h0) begin
         n_err++; $display("FAIL reset_idle_rdata: got %h expected 00000000", bus_if.bus_read_data);
      end
      nreset = 1'b1;
      cycles(1);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL reset_status: got %h expected 00000000", d);
      end
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL reset_ctrl: got %h expected 00000000", d);
      end
      cycles(RESET_CYCLES + 20);
   endtask

   // 1s at exactly BIT_THRESH, 0s alternating BIT_THRESH-1 and MIN_HIGH
   task automatic test_thresh();
      logic [31:0] d;
      logic [23:0] p;
      p = 24'h96C3A5;
      for (int i = 23; i >= 0; i--) begin
         if (p[i])           send_bit_w(15, 16);
         else if (i % 2 != 0) send_bit_w(14, 16);
         else                send_bit_w(3, 16);
      end
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0396C3A5) begin
         n_err++; $display("FAIL thresh_status: got %h expected 0396C3A5", d);
      end
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h00000001) begin
         n_err++; $display("FAIL thresh_count: got %h expected 00000001", d);
      end
      wr(32'h04000000);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0096C3A5) begin
         n_err++; $display("FAIL thresh_clear: got %h expected 0096C3A5", d);
      end
   endtask

   task automatic test_single();
      logic [31:0] d;
      send_bits(48'hA50F3C, 24);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h03A50F3C) begin
         n_err++; $display("FAIL single_status: got %h expected 03A50F3C", d);
      end
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h00000001) begin
         n_err++; $display("FAIL single_count: got %h expected 00000001", d);
      end
      wr(32'h04000000);
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      send_bits(48'h123456, 24);
      send_bits(48'hABCDEF, 24);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0BABCDEF) begin
         n_err++; $display("FAIL b2b_status: got %h expected 0BABCDEF", d);
      end
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h00000002) begin
         n_err++; $display("FAIL b2b_count: got %h expected 00000002", d);
      end
      wr(32'h05000000);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h00ABCDEF) begin
         n_err++; $display("FAIL b2b_clear: got %h expected 00ABCDEF", d);
      end
   endtask

   task automatic test_glitch();
      logic [31:0] d;
      send_bits(48'h5A, 8);
      np_in = 1'b1;
      cycles(2);
      np_in = 1'b0;
      cycles(10);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h04ABCDEF) begin
         n_err++; $display("FAIL glitch_err: got %h expected 04ABCDEF", d);
      end
      send_bits(48'hFFFF, 16);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h04ABCDEF) begin
         n_err++; $display("FAIL glitch_ignored: got %h expected 04ABCDEF", d);
      end
      send_bits(48'h5A5A5A, 24);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h075A5A5A) begin
         n_err++; $display("FAIL glitch_recover: got %h expected 075A5A5A", d);
      end
      wr(32'h06000000);
   endtask

   task automatic test_partial_irq();
      logic [31:0] d;
      logic        found;
      logic        irq0, irq1;
      found = 1'b0;
      irq0  = 1'b0;
      d     = '0;
      wr(32'h18000000);
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h00000101) begin
         n_err++; $display("FAIL irq_enable: got %h expected 00000101", d);
      end
      send_bits(48'hABC, 12);
      bus_if.np_en       = 1'b1;
      bus_if.bus_read_en = 1'b1;
      bus_if.bus_addr    = REG_STATUS;
      for (int k = 0; k < 1400 && !found; k++) begin
         #1;
         if (bus_if.bus_read_data[ST_DONE]) begin
            found = 1'b1;
            d     = bus_if.bus_read_data;
            irq0  = np_irq;
         end
         @(negedge pclk);
      end
      #1 irq1 = np_irq;
      bus_if.np_en       = 1'b0;
      bus_if.bus_read_en = 1'b0;
      n_vec++;
      if (found !== 1'b1) begin
         n_err++; $display("FAIL partial_timeout: got found=%b expected 1", found);
      end
      n_vec++;
      if (d !== 32'h065A5A5A) begin
         n_err++; $display("FAIL partial_status: got %h expected 065A5A5A", d);
      end
      n_vec++;
      if (irq0 !== 1'b0) begin
         n_err++; $display("FAIL partial_irq_same_cycle: got %b expected 0", irq0);
      end
      n_vec++;
      if (irq1 !== 1'b1) begin
         n_err++; $display("FAIL partial_irq_next_cycle: got %b expected 1", irq1);
      end
      wr(32'h06000000);
      cycles(2);
      n_vec++;
      if (np_irq !== 1'b0) begin
         n_err++; $display("FAIL irq_clear: got %b expected 0", np_irq);
      end
   endtask

   task automatic test_read_race();
      logic [31:0] d, d0;
      send_bits(48'h007F80, 23);
      np_in = 1'b1;
      cycles(10);
      np_in = 1'b0;
      cycles(2);
      bus_if.np_en       = 1'b1;
      bus_if.bus_read_en = 1'b1;
      bus_if.bus_addr    = REG_STATUS;
      #1 d0 = bus_if.bus_read_data;
      @(negedge pclk);
      bus_if.np_en       = 1'b0;
      bus_if.bus_read_en = 1'b0;
      n_vec++;
      if (d0 !== 32'h005A5A5A) begin
         n_err++; $display("FAIL race_before: got %h expected 005A5A5A", d0);
      end
      cycles(5);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0100FF00) begin
         n_err++; $display("FAIL race_valid_kept: got %h expected 0100FF00", d);
      end
   endtask

   task automatic test_midframe_reset();
      logic [31:0] d;
      send_bits(48'h3FF, 10);
      nreset = 1'b0;
      cycles(2);
      nreset = 1'b1;
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL midreset_status: got %h expected 00000000", d);
      end
      rd(REG_CTRL, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL midreset_ctrl: got %h expected 00000000", d);
      end
      send_bits(48'h123456, 24);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h0) begin
         n_err++; $display("FAIL midreset_armed: got %h expected 00000000", d);
      end
      send_bits(48'h3C3C3C, 24);
      cycles(1300);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h033C3C3C) begin
         n_err++; $display("FAIL midreset_recover: got %h expected 033C3C3C", d);
      end
      wr(32'h04000000);
   endtask

`ifdef NEOPIXEL_RX_FWD_EN
   task automatic fwd_tick(input logic v, input logic window);
      logic exp;
      np_in    = v;
      fwd_hist = {fwd_hist[1:0], v};
      @(negedge pclk);
      exp = window ? fwd_hist[1] : 1'b0;
      fwd_ticks++;
      if (np_fwd_out !== exp) begin
         if (fwd_bad == 0)
            $display("FAIL fwd_stream: tick %0d got %b expected %b", fwd_ticks, np_fwd_out, exp);
         fwd_bad++;
      end
   endtask

   task automatic fwd_bits(input logic [23:0] v, input logic window);
      for (int i = 23; i >= 0; i--) begin
         for (int t = 0; t < 31; t++) fwd_tick((t < (v[i] ? 20 : 10)) ? 1'b1 : 1'b0, window);
      end
   endtask

   task automatic test_fwd();
      logic [31:0] d;
      fwd_hist  = '0;
      fwd_bad   = 0;
      fwd_ticks = 0;
      fwd_bits(24'hC3A55A, 1'b0);
      fwd_bits(24'h96E10F, 1'b1);
      for (int t = 0; t < 1300; t++) fwd_tick(1'b0, 1'b1);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h03C3A55A) begin
         n_err++; $display("FAIL fwd_capture: got %h expected 03C3A55A", d);
      end
      wr(32'h04000000);
      fwd_hist = '0;
      fwd_bits(24'h0F0F0F, 1'b0);
      for (int t = 0; t < 1300; t++) fwd_tick(1'b0, 1'b0);
      rd(REG_STATUS, d);
      n_vec++;
      if (d !== 32'h030F0F0F) begin
         n_err++; $display("FAIL fwd_next_frame: got %h expected 030F0F0F", d);
      end
      n_vec++;
      if (fwd_bad != 0) begin
         n_err++; $display("FAIL fwd_stream_total: got %0d bad ticks expected 0", fwd_bad);
      end
   endtask
`endif

   initial begin
      bus_if.bus_write_en   = 1'b0;
      bus_if.bus_read_en    = 1'b0;
      bus_if.np_en          = 1'b0;
      bus_if.bus_addr       = '0;
      bus_if.bus_write_data = '0;
      @(negedge pclk);
      test_reset();
      test_thresh();
      test_single();
      test_back_to_back();
      test_glitch();
      test_partial_irq();
      test_read_race();
      test_midframe_reset();
`ifdef NEOPIXEL_RX_FWD_EN
      test_fwd();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
